// File: rtl/rsa_exp_ctrl_if.sv
// Start/done handshake bundle between the exponentiation sequencer and the
// shared Montgomery multiplier.
interface rsa_exp_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             mmm_start;
  logic [WIDTH-1:0] mmm_a;
  logic [WIDTH-1:0] mmm_b;
  logic [WIDTH-1:0] mmm_p;
  logic             mmm_done;
  logic [WIDTH-1:0] mmm_result;

  modport master (
    output mmm_start, mmm_a, mmm_b, mmm_p,
    input  mmm_done, mmm_result
  );

  modport slave (
    input  mmm_start, mmm_a, mmm_b, mmm_p,
    output mmm_done, mmm_result
  );
endinterface

// File: rtl/rsa_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing c = m^e mod p by
// issuing one Montgomery multiplication per state.
module rsa_exp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start_cmd,
  input  logic             stop_cmd,
  input  logic [WIDTH-1:0] rsa_p,
  input  logic [WIDTH-1:0] rsa_e,
  input  logic [WIDTH-1:0] rsa_m,
  input  logic [WIDTH-1:0] rsa_const,
  rsa_exp_ctrl_if.master   mmm,
  output logic [WIDTH-1:0] rsa_c,
  output logic             eoc,
  output logic             busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]    I_TOP = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE, PRE_M, PRE_X, SQUARE, MULT, POST, DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [IW-1:0]    i_reg, i_next;
  logic [WIDTH-1:0] p_reg, e_reg, const_reg;
  logic [WIDTH-1:0] mbar_reg, mbar_next;
  logic [WIDTH-1:0] x_reg, x_next;
  logic [WIDTH-1:0] c_reg, c_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             start_reg, start_next;
  logic             load;
  logic             done_ok;

  // A done coinciding with our own start pulse belongs to no operation of ours.
  assign done_ok = mmm.mmm_done & ~start_reg;

  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    mbar_next  = mbar_reg;
    x_next     = x_reg;
    c_next     = c_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    start_next = 1'b0;
    load       = 1'b0;
    if (stop_cmd) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (start_cmd) begin
          load       = 1'b1;
          i_next     = I_TOP;
          state_next = PRE_M;
          start_next = 1'b1;
          a_next     = rsa_m;
          b_next     = rsa_const;
        end
        PRE_M: if (done_ok) begin
          mbar_next  = mmm.mmm_result;
          state_next = PRE_X;
          start_next = 1'b1;
          a_next     = ONE;
          b_next     = const_reg;
        end
        PRE_X: if (done_ok) begin
          x_next     = mmm.mmm_result;
          state_next = SQUARE;
          start_next = 1'b1;
          a_next     = mmm.mmm_result;
          b_next     = mmm.mmm_result;
        end
        SQUARE, MULT: if (done_ok) begin
          x_next     = mmm.mmm_result;
          start_next = 1'b1;
          if (state_reg == SQUARE && e_reg[i_reg]) begin
            state_next = MULT;
            a_next     = mbar_reg;
            b_next     = mmm.mmm_result;
          end else if (i_reg == '0) begin
            state_next = POST;
            a_next     = mmm.mmm_result;
            b_next     = ONE;
          end else begin
            i_next     = i_reg - 1'b1;
            state_next = SQUARE;
            a_next     = mmm.mmm_result;
            b_next     = mmm.mmm_result;
          end
        end
        POST: if (done_ok) begin
          c_next     = mmm.mmm_result;
          state_next = DONE;
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      i_reg     <= '0;
      p_reg     <= '0;
      e_reg     <= '0;
      const_reg <= '0;
      mbar_reg  <= '0;
      x_reg     <= '0;
      c_reg     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      start_reg <= 1'b0;
    end else if (ena) begin
      state_reg <= state_next;
      i_reg     <= i_next;
      mbar_reg  <= mbar_next;
      x_reg     <= x_next;
      c_reg     <= c_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      start_reg <= start_next;
      if (load) begin
        p_reg     <= rsa_p;
        e_reg     <= rsa_e;
        const_reg <= rsa_const;
      end
    end
  end

  assign mmm.mmm_start = start_reg & ena;
  assign mmm.mmm_a     = a_reg;
  assign mmm.mmm_b     = b_reg;
  assign mmm.mmm_p     = p_reg;
  assign rsa_c         = c_reg;
  assign eoc           = (state_reg == DONE) & ena;
  assign busy          = (state_reg != IDLE);

endmodule
